// File: rtl/asteroid_spawner.sv
// Asteroid spawner: queues timer fire pulses, finds the lowest free table slot
// and issues a random edge spawn position/heading over a valid/ready handshake.
module asteroid_spawner #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PEND_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fire,
  input  logic [15:0]          rand_in,
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic                 spawn_valid,
  input  logic                 spawn_ready,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [9:0]           spawn_x,
  output logic [8:0]           spawn_y,
  output logic [2:0]           spawn_dir,
  output logic [1:0]           pend_count,
  output logic                 drop_pulse
);

  localparam logic [9:0] SW   = 10'(SCREEN_W);
  localparam logic [9:0] XMAX = 10'(SCREEN_W - 1);
  localparam logic [8:0] SH   = 9'(SCREEN_H);
  localparam logic [8:0] YMAX = 9'(SCREEN_H - 1);
  localparam logic [1:0] PMAX = 2'(PEND_MAX);

  typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_t;
  state_t state;

  logic              hs;
  logic              found;
  logic [SLOT_W-1:0] free_idx;
  logic [9:0]        rx, fx, nx;
  logic [8:0]        ry, fy, ny;
  logic              unused_bit;

  assign hs         = spawn_valid & spawn_ready;
  assign unused_bit = rand_in[15];

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        found    = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  // Raw fields exceed the playfield by less than one screen, so one fold suffices.
  always_comb begin
    rx = rand_in[11:2];
    ry = rand_in[10:2];
    fx = (rx >= SW) ? rx - SW : rx;
    fy = (ry >= SH) ? ry - SH : ry;
    nx = fx;
    ny = fy;
    case (rand_in[1:0])
      2'd0: begin nx = fx;   ny = '0;   end
      2'd1: begin nx = fx;   ny = YMAX; end
      2'd2: begin nx = '0;   ny = fy;   end
      default: begin nx = XMAX; ny = fy; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_count  <= '0;
      drop_pulse  <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
      spawn_y     <= '0;
      spawn_dir   <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (fire && !hs) begin
        if (pend_count == PMAX) drop_pulse <= 1'b1;
        else                    pend_count <= pend_count + 2'd1;
      end else if (hs && !fire) begin
        pend_count <= pend_count - 2'd1;
      end

      case (state)
        IDLE: if (pend_count != 2'd0) state <= SEARCH;
        SEARCH: begin
          if (found) begin
            spawn_slot  <= free_idx;
            spawn_x     <= nx;
            spawn_y     <= ny;
            spawn_dir   <= rand_in[14:12];
            spawn_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Decision uses the pre-handshake count; a coincident fire is picked up from IDLE.
          if (hs) begin
            spawn_valid <= 1'b0;
            state       <= (pend_count > 2'd1) ? SEARCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asteroid_spawner.sv
// Bench for asteroid_spawner: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the spawn rules.
module tb_asteroid_spawner;
  logic        clk = 1'b0;
  logic        rst, fire, spawn_ready;
  logic [15:0] rand_in;
  logic [7:0]  slot_active;
  logic        spawn_valid, drop_pulse;
  logic [2:0]  spawn_slot, spawn_dir;
  logic [9:0]  spawn_x;
  logic [8:0]  spawn_y;
  logic [1:0]  pend_count;

  asteroid_spawner dut (
    .clk(clk), .rst(rst), .fire(fire), .rand_in(rand_in),
    .slot_active(slot_active), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_slot(spawn_slot), .spawn_x(spawn_x),
    .spawn_y(spawn_y), .spawn_dir(spawn_dir), .pend_count(pend_count),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference state: queue depth, busy phase (0 idle, 1 hunting, 2 offering), held payload.
  int m_pend, m_phase, m_valid, m_slot, m_x, m_y, m_dir, m_drop;
  bit tbl_auto;
  int hs_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void spawn_of(input logic [15:0] r, output int x, output int y, output int d);
    int rx, ry;
    rx = int'(r[11:2]) % 640;
    ry = int'(r[10:2]) % 480;
    case (r[1:0])
      2'd0: begin x = rx;  y = 0;   end
      2'd1: begin x = rx;  y = 479; end
      2'd2: begin x = 0;   y = ry;  end
      default: begin x = 639; y = ry; end
    endcase
    d = int'(r[14:12]);
  endfunction

  task automatic model_clear();
    m_pend = 0; m_phase = 0; m_valid = 0; m_slot = 0;
    m_x = 0; m_y = 0; m_dir = 0; m_drop = 0;
  endtask

  task automatic compare();
    chk("valid", spawn_valid, m_valid);
    chk("pend", pend_count, m_pend);
    chk("drop", drop_pulse, m_drop);
    if (m_valid != 0) begin
      chk("slot", spawn_slot, m_slot);
      chk("x", spawn_x, m_x);
      chk("y", spawn_y, m_y);
      chk("dir", spawn_dir, m_dir);
    end
  endtask

  // Advance one clock: predict from current inputs, clock, then compare.
  task automatic tick();
    bit hs;
    int lowest, n_pend, hs_slot, x, y, d;
    hs = (m_valid != 0) && spawn_ready;
    hs_slot = m_slot;
    if (spawn_valid && spawn_ready) hs_q.push_back(int'(spawn_slot));
    lowest = -1;
    for (int i = 7; i >= 0; i--) if (!slot_active[i]) lowest = i;
    m_drop = (fire && !hs && m_pend == 3) ? 1 : 0;
    n_pend = m_pend;
    if (fire && !hs) n_pend = (m_pend < 3) ? m_pend + 1 : 3;
    else if (hs && !fire) n_pend = m_pend - 1;
    case (m_phase)
      0: if (m_pend > 0) m_phase = 1;
      1: if (lowest >= 0) begin
           spawn_of(rand_in, x, y, d);
           m_slot = lowest; m_x = x; m_y = y; m_dir = d;
           m_valid = 1; m_phase = 2;
         end
      default: if (hs) begin
           m_valid = 0;
           m_phase = (m_pend - 1 > 0) ? 1 : 0;
         end
    endcase
    m_pend = n_pend;
    @(posedge clk);
    #1;
    if (hs && tbl_auto) slot_active[hs_slot] = 1'b1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", spawn_valid, 0);
    chk("rst_pend", pend_count, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_slot", spawn_slot, 0);
    chk("rst_x", spawn_x, 0);
    chk("rst_y", spawn_y, 0);
    chk("rst_dir", spawn_dir, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    fire = 0; spawn_ready = 0; rand_in = '0; slot_active = '0; tbl_auto = 1;
    model_clear();
    do_reset();

    // T1: reset with requests in flight
    fire = 1; tick(); tick(); tick();
    fire = 0; tick();
    do_reset();
    tick();

    // T2: single spawn, right edge
    slot_active = 8'h07; rand_in = 16'h1A0F; spawn_ready = 1;
    fire = 1; tick();
    fire = 0; tick();
    chk("t2_lat_valid", spawn_valid, 0);
    tick();
    chk("t2_valid", spawn_valid, 1);
    chk("t2_slot", spawn_slot, 3);
    chk("t2_x", spawn_x, 639);
    chk("t2_y", spawn_y, 131);
    chk("t2_dir", spawn_dir, 1);
    tick();
    chk("t2_pend", pend_count, 0);
    tick(); tick();
    chk("t2_idle", spawn_valid, 0);

    // T3: fold on top edge, payload held while inputs wander
    slot_active = 8'h00; rand_in = 16'h0FA0; spawn_ready = 0;
    fire = 1; tick();
    fire = 0; tick(); tick();
    chk("t3_x", spawn_x, 360);
    chk("t3_y", spawn_y, 0);
    chk("t3_dir", spawn_dir, 0);
    rand_in = 16'hFFFF; slot_active = 8'hF0; tick();
    chk("t3_hold_x", spawn_x, 360);
    spawn_ready = 1; tick(); tick();

    // T4: full table, then slot 5 frees
    slot_active = 8'hFF; spawn_ready = 0; rand_in = 16'h5432;
    fire = 1; tick();
    fire = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_blocked", spawn_valid, 0);
    chk("t4_pend", pend_count, 1);
    slot_active = 8'hDF; tick();
    chk("t4_slot", spawn_slot, 5);
    spawn_ready = 1; tick(); tick();

    // T5: saturation and coincident fire/handshake
    slot_active = 8'hFF; spawn_ready = 0;
    fire = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_nodrop", drop_pulse, 0);
    end
    chk("t5_pend3", pend_count, 3);
    tick();
    chk("t5_drop", drop_pulse, 1);
    chk("t5_hold", pend_count, 3);
    fire = 0; tick();
    chk("t5_drop_clr", drop_pulse, 0);
    slot_active = 8'hFE; tick();
    chk("t5_offer", spawn_valid, 1);
    spawn_ready = 1; fire = 1; tick();
    chk("t5_coinc_pend", pend_count, 3);
    chk("t5_coinc_drop", drop_pulse, 0);
    fire = 0; slot_active = 8'h00;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_drained", pend_count, 0);

    // T6: back-to-back issue with ready held
    slot_active = 8'h00; spawn_ready = 1; hs_q.delete();
    fire = 1; tick(); tick();
    fire = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("t6_first", hs_q[0], 0);
      chk("t6_second", hs_q[1], 1);
    end
    chk("t6_idle", spawn_valid, 0);

    // Random traffic with a table that occupies on handshake and frees at random
    slot_active = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      fire = ($urandom_range(0, 3) == 0);
      spawn_ready = $urandom_range(0, 1);
      rand_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) slot_active[$urandom_range(0, 7)] = 1'b0;
      if (c == 1500) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
